// File: rtl/outinf.sv
`default_nettype none
// ============================================================================
//  Module   : outinf
//  Purpose  : Output-side pixel interface of the convolution engine. Buffers
//             result pixels from the core in a small FIFO and streams them
//             out over a valid/ready interface. Each pixel carries row and
//             frame end markers derived from the latched frame config.
//             `done` is high while the frame is complete.
//  Ports    : clk, rst (async, active-low)
//             cfg_width/cfg_height/start : frame config and start request
//             res_data/res_valid/res_ready : input from compute core
//             px_out_data/valid/ready/last_x/last_y : output stream
//             done : frame fully transmitted
//  Revision : 1.0 - initial release
// ============================================================================
module outinf #(
  parameter int XB    = 10,
  parameter int YB    = 10,
  parameter int PB    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [XB-1:0] cfg_width,
  input  logic [YB-1:0] cfg_height,
  input  logic          start,
  input  logic [PB-1:0] res_data,
  input  logic          res_valid,
  output logic          res_ready,
  output logic [PB-1:0] px_out_data,
  output logic          px_out_valid,
  input  logic          px_out_ready,
  output logic          px_out_last_x,
  output logic          px_out_last_y,
  output logic          done
);

  localparam int c_AW = $clog2(DEPTH);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_next_state;

  logic [XB-1:0] r_width;
  logic [YB-1:0] r_height;
  logic [XB-1:0] r_ix;
  logic [YB-1:0] r_iy;
  logic          r_in_done;
  logic [XB-1:0] r_ox;
  logic [YB-1:0] r_oy;
  logic [c_AW:0] r_wptr;
  logic [c_AW:0] r_rptr;
  logic [PB-1:0] r_mem [DEPTH];

  logic [XB-1:0] w_wm1;
  logic [YB-1:0] w_hm1;
  logic          w_full;
  logic          w_empty;
  logic          w_start_acc;
  logic          w_push;
  logic          w_pop;

  // Only meaningful in RUN, where the latched sizes are at least 1.
  assign w_wm1 = r_width - XB'(1);
  assign w_hm1 = r_height - YB'(1);

  assign w_full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                   (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
  assign w_empty = (r_wptr == r_rptr);

  assign w_start_acc = start && (r_state != c_RUN);
  assign w_push      = res_valid && res_ready;
  assign w_pop       = px_out_valid && px_out_ready;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= c_IDLE;
    else      r_state <= w_next_state;
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE, c_DONE: begin
        if (start) begin
          if ((cfg_width != '0) && (cfg_height != '0)) w_next_state = c_RUN;
          else                                         w_next_state = c_DONE;
        end
      end
      c_RUN: begin
        if (w_pop && px_out_last_x && px_out_last_y) w_next_state = c_DONE;
      end
      default: w_next_state = c_IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    res_ready     = 1'b0;
    px_out_valid  = 1'b0;
    done          = 1'b0;
    if (r_state == c_RUN) begin
      res_ready    = !w_full && !r_in_done;
      px_out_valid = !w_empty;
    end
    if (r_state == c_DONE) done = 1'b1;
    px_out_last_x = px_out_valid && (r_ox == w_wm1);
    px_out_last_y = px_out_valid && (r_oy == w_hm1);
    // Masked so stale FIFO contents never show while nothing is offered.
    px_out_data   = px_out_valid ? r_mem[r_rptr[c_AW-1:0]] : '0;
  end

  // ----------------------------------------------------- counters / pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_width   <= '0;
      r_height  <= '0;
      r_ix      <= '0;
      r_iy      <= '0;
      r_in_done <= 1'b0;
      r_ox      <= '0;
      r_oy      <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
    end else if (w_start_acc) begin
      r_width   <= cfg_width;
      r_height  <= cfg_height;
      r_ix      <= '0;
      r_iy      <= '0;
      r_in_done <= 1'b0;
      r_ox      <= '0;
      r_oy      <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
        if (r_ix == w_wm1) begin
          r_ix <= '0;
          r_iy <= r_iy + 1'b1;
          if (r_iy == w_hm1) r_in_done <= 1'b1;
        end else begin
          r_ix <= r_ix + 1'b1;
        end
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        if (r_ox == w_wm1) begin
          r_ox <= '0;
          r_oy <= r_oy + 1'b1;
        end else begin
          r_ox <= r_ox + 1'b1;
        end
      end
    end
  end

  // FIFO storage needs no reset: entries are only read when the pointers
  // say they were written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[c_AW-1:0]] <= res_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_outinf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_outinf
//  Purpose  : Self-checking bench for outinf. A queue-based reference model
//             predicts the output stream, end markers and flow control.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_outinf;

  localparam int c_DEPTH  = 4;
  localparam int c_BUDGET = 3000;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] cfg_width;
  logic [9:0] cfg_height;
  logic       start;
  logic [7:0] res_data;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] px_out_data;
  logic       px_out_valid;
  logic       px_out_ready;
  logic       px_out_last_x;
  logic       px_out_last_y;
  logic       done;

  int errors = 0;
  int checks = 0;

  outinf #(.XB(10), .YB(10), .PB(8), .DEPTH(c_DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_width     (cfg_width),
    .cfg_height    (cfg_height),
    .start         (start),
    .res_data      (res_data),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .px_out_data   (px_out_data),
    .px_out_valid  (px_out_valid),
    .px_out_ready  (px_out_ready),
    .px_out_last_x (px_out_last_x),
    .px_out_last_y (px_out_last_y),
    .done          (done)
  );

  always #5 clk = ~clk;

  // Issues a start at the current negedge; returns at the following negedge.
  task automatic do_start(input int w, input int h);
    cfg_width  = 10'(w);
    cfg_height = 10'(h);
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== ((w == 0) || (h == 0))) begin
      errors++;
      $display("FAIL start_done w=%0d h=%0d got=%b exp=%b", w, h, done, (w == 0) || (h == 0));
    end
  endtask

  // Streams one w x h frame with random data. vp/rp are percent probabilities
  // of res_valid / px_out_ready; px_out_ready is forced low during the stall
  // window; a start is injected at cycle restart_at (ignored by design).
  task automatic run_frame(input int w, input int h, input int vp, input int rp,
                           input int stall_at, input int stall_len, input int restart_at,
                           output int first_pop, output int last_pop, output int max_occ);
    int q[$];
    int pushed = 0;
    int popped = 0;
    int cyc = 0;
    int total = w * h;
    bit prev_stall = 0;
    logic [7:0] s_data;
    logic s_lx, s_ly;
    bit exp_lx, exp_ly;
    first_pop = -1;
    last_pop  = -1;
    max_occ   = 0;
    while (popped < total && cyc < c_BUDGET) begin
      if (q.size() > max_occ) max_occ = q.size();
      checks++;
      if (res_ready !== ((q.size() < c_DEPTH) && (pushed < total))) begin
        errors++;
        $display("FAIL res_ready cyc=%0d got=%b occ=%0d pushed=%0d", cyc, res_ready, q.size(), pushed);
      end
      checks++;
      if (px_out_valid !== (q.size() > 0)) begin
        errors++;
        $display("FAIL px_out_valid cyc=%0d got=%b occ=%0d", cyc, px_out_valid, q.size());
      end
      if (prev_stall) begin
        checks++;
        if (px_out_valid !== 1'b1 || px_out_data !== s_data ||
            px_out_last_x !== s_lx || px_out_last_y !== s_ly) begin
          errors++;
          $display("FAIL stall_hold cyc=%0d got v=%b d=%h lx=%b ly=%b exp v=1 d=%h lx=%b ly=%b",
                   cyc, px_out_valid, px_out_data, px_out_last_x, px_out_last_y, s_data, s_lx, s_ly);
        end
      end
      // drive this cycle's inputs
      res_valid = ($urandom_range(99) < vp);
      res_data  = 8'($urandom);
      if (cyc >= stall_at && cyc < stall_at + stall_len) px_out_ready = 1'b0;
      else px_out_ready = ($urandom_range(99) < rp);
      if (cyc == restart_at) begin
        cfg_width  = 10'd2;
        cfg_height = 10'd7;
        start      = 1'b1;
      end else begin
        start = 1'b0;
      end
      // output side of the model
      if (px_out_valid && px_out_ready) begin
        exp_lx = ((popped % w) == w - 1);
        exp_ly = ((popped / w) == h - 1);
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL pop_empty cyc=%0d got valid=1 exp valid=0", cyc);
        end else if (px_out_data !== 8'(q[0]) || px_out_last_x !== exp_lx || px_out_last_y !== exp_ly) begin
          errors++;
          $display("FAIL pixel k=%0d got d=%h lx=%b ly=%b exp d=%h lx=%b ly=%b",
                   popped, px_out_data, px_out_last_x, px_out_last_y, 8'(q[0]), exp_lx, exp_ly);
        end
        if (q.size() > 0) void'(q.pop_front());
        popped++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
      prev_stall = px_out_valid && !px_out_ready;
      s_data = px_out_data;
      s_lx   = px_out_last_x;
      s_ly   = px_out_last_y;
      // input side of the model
      if (res_valid && res_ready) begin
        q.push_back(int'(res_data));
        pushed++;
      end
      @(negedge clk);
      cyc++;
    end
    start        = 1'b0;
    res_valid    = 1'b0;
    px_out_ready = 1'b0;
    checks++;
    if (popped != total) begin
      errors++;
      $display("FAIL frame_timeout w=%0d h=%0d got popped=%0d exp=%0d", w, h, popped, total);
    end
    checks++;
    if (done !== 1'b1 || px_out_valid !== 1'b0 || res_ready !== 1'b0) begin
      errors++;
      $display("FAIL frame_end got done=%b valid=%b rdy=%b exp done=1 valid=0 rdy=0",
               done, px_out_valid, res_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({res_ready, px_out_valid, px_out_last_x, px_out_last_y, done, px_out_data} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b v=%b lx=%b ly=%b done=%b d=%h exp all 0",
               res_ready, px_out_valid, px_out_last_x, px_out_last_y, done, px_out_data);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({res_ready, px_out_valid, done} !== 3'd0) begin
      errors++;
      $display("FAIL idle_outputs got rdy=%b v=%b done=%b exp 0", res_ready, px_out_valid, done);
    end
  endtask

  task automatic test_frame_4x3();
    int fp, lp, mo;
    do_start(4, 3);
    run_frame(4, 3, 100, 100, -1, 0, -1, fp, lp, mo);
    checks++;
    if (fp != 1 || lp - fp != 11) begin
      errors++;
      $display("FAIL throughput got first=%0d span=%0d exp first=1 span=11", fp, lp - fp);
    end
  endtask

  task automatic test_backpressure();
    int fp, lp, mo;
    do_start(4, 3);
    run_frame(4, 3, 100, 100, 3, 10, -1, fp, lp, mo);
    checks++;
    if (mo != c_DEPTH) begin
      errors++;
      $display("FAIL fifo_fill got max_occ=%0d exp=%0d", mo, c_DEPTH);
    end
  endtask

  task automatic test_1x1();
    int fp, lp, mo;
    do_start(1, 1);
    run_frame(1, 1, 100, 100, -1, 0, -1, fp, lp, mo);
    res_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (res_ready !== 1'b0 || done !== 1'b1) begin
        errors++;
        $display("FAIL post_1x1 got rdy=%b done=%b exp rdy=0 done=1", res_ready, done);
      end
    end
    res_valid = 1'b0;
    do_start(3, 2);
    run_frame(3, 2, 70, 60, -1, 0, -1, fp, lp, mo);
  endtask

  task automatic test_zero_size();
    int fp, lp, mo;
    do_start(0, 3);
    res_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (res_ready !== 1'b0 || done !== 1'b1) begin
        errors++;
        $display("FAIL zero_w got rdy=%b done=%b exp rdy=0 done=1", res_ready, done);
      end
      @(negedge clk);
    end
    res_valid = 1'b0;
    do_start(5, 0);
    checks++;
    if (res_ready !== 1'b0) begin
      errors++;
      $display("FAIL zero_h got rdy=%b exp 0", res_ready);
    end
    do_start(2, 2);
    run_frame(2, 2, 80, 80, -1, 0, -1, fp, lp, mo);
  endtask

  task automatic test_start_in_run();
    int fp, lp, mo;
    do_start(4, 2);
    run_frame(4, 2, 100, 100, -1, 0, 3, fp, lp, mo);
  endtask

  task automatic test_reset_midframe();
    int fp, lp, mo;
    int n = 0;
    do_start(4, 3);
    res_valid    = 1'b1;
    res_data     = 8'h5a;
    px_out_ready = 1'b1;
    for (int c = 0; c < 50 && n < 5; c++) begin
      if (px_out_valid && px_out_ready) n++;
      @(negedge clk);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({res_ready, px_out_valid, px_out_last_x, px_out_last_y, done, px_out_data} !== 13'd0) begin
      errors++;
      $display("FAIL async_reset got rdy=%b v=%b lx=%b ly=%b done=%b d=%h exp all 0",
               res_ready, px_out_valid, px_out_last_x, px_out_last_y, done, px_out_data);
    end
    res_valid    = 1'b0;
    px_out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_start(4, 3);
    run_frame(4, 3, 100, 100, -1, 0, -1, fp, lp, mo);
  endtask

  task automatic test_random();
    int fp, lp, mo, w, h;
    for (int f = 0; f < 4; f++) begin
      w = int'($urandom_range(6, 1));
      h = int'($urandom_range(5, 1));
      do_start(w, h);
      run_frame(w, h, 60, 50, -1, 0, -1, fp, lp, mo);
    end
  endtask

  initial begin
    cfg_width    = '0;
    cfg_height   = '0;
    start        = 1'b0;
    res_data     = '0;
    res_valid    = 1'b0;
    px_out_ready = 1'b0;
    test_reset();
    test_frame_4x3();
    test_backpressure();
    test_1x1();
    test_zero_size();
    test_start_in_run();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
